mix_columns_engine: RTL and testbench

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

---
 rtl/mix_columns_engine.sv | 131 +++++++++++++
 tb/tb_mix_columns_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine: one 32-bit column per cycle,
// written back in place into a block-wide state register.
module mix_columns_engine #(
  parameter int NCOL = 4,
  parameter int DW   = 32 * NCOL
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  input  logic          IN_INV,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic          BUSY
);

  localparam int            CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCOL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_fsm;
  state_t        w_fsm_nxt;
  logic [DW-1:0] r_state;
  logic [DW-1:0] w_state_wb;
  logic          r_inv;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic [31:0]   w_col;
  logic [31:0]   w_mix;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 of a column is its most significant byte (big-endian numbering).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      if (inv)
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                         ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                         ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                         ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      else
        res[31-8*r -: 8] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

  always_comb begin
    w_col      = '0;
    w_state_wb = r_state;
    for (int c = 0; c < NCOL; c++)
      if (r_cnt == CW'(c)) w_col = r_state[DW-1-32*c -: 32];
    w_mix = mix_col(w_col, r_inv);
    for (int c = 0; c < NCOL; c++)
      if (r_cnt == CW'(c)) w_state_wb[DW-1-32*c -: 32] = w_mix;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // DONE with OUT_READY forms a pass-through slot: consume and accept in one cycle.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_accept  = 1'b0;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    case (r_fsm)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          w_accept  = 1'b1;
          w_fsm_nxt = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        if (r_cnt == LAST) w_fsm_nxt = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        IN_READY  = OUT_READY;
        if (OUT_READY) begin
          if (IN_VALID) begin
            w_accept  = 1'b1;
            w_fsm_nxt = RUN;
          end else begin
            w_fsm_nxt = IDLE;
          end
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= '0;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= IN_DATA;
      r_inv   <= IN_INV;
      r_cnt   <= '0;
    end else if (r_fsm == RUN) begin
      r_state <= w_state_wb;
      if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign OUT_DATA = r_state;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine: NCOL=4 main instance plus NCOL=1 and NCOL=8 spot checks.
module tb_mix_columns_engine;

  localparam int N  = 4;
  localparam int W  = 32 * N;
  localparam int LAT = N + 1;

  localparam logic [W-1:0] V_F_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [W-1:0] V_F_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [W-1:0] V_I_IN  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
  localparam logic [W-1:0] V_I_OUT = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv = 1'b0, ii = 1'b0, ordy = 1'b0;
  logic [W-1:0] idat = '0;
  logic         irdy, ovld, busy;
  logic [W-1:0] odat;

  logic         v1 = 1'b0, v8 = 1'b0, ordy_s = 1'b1;
  logic [31:0]  d1 = '0;
  logic [255:0] d8 = '0;
  logic         rdy1, ov1, busy1, rdy8, ov8, busy8;
  logic [31:0]  o1;
  logic [255:0] o8;

  always #5 clk = ~clk;

  mix_columns_engine #(.NCOL(N)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(irdy), .IN_DATA(idat), .IN_INV(ii),
    .OUT_VALID(ovld), .OUT_READY(ordy), .OUT_DATA(odat), .BUSY(busy));

  mix_columns_engine #(.NCOL(1)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(v1), .IN_READY(rdy1), .IN_DATA(d1), .IN_INV(1'b0),
    .OUT_VALID(ov1), .OUT_READY(ordy_s), .OUT_DATA(o1), .BUSY(busy1));

  mix_columns_engine #(.NCOL(8)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(rdy8), .IN_DATA(d8), .IN_INV(1'b0),
    .OUT_VALID(ov8), .OUT_READY(ordy_s), .OUT_DATA(o8), .BUSY(busy8));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic: plain shift-and-add GF(2^8) product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = s[7] ? ((s << 1) ^ 8'h1b) : (s << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] mcol(input logic [31:0] c, input logic inv);
    logic [7:0]  a [4];
    logic [7:0]  k [4];
    logic [7:0]  b;
    logic [31:0] res = '0;
    for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
    if (inv) begin k[0] = 8'd14; k[1] = 8'd11; k[2] = 8'd13; k[3] = 8'd9; end
    else     begin k[0] = 8'd2;  k[1] = 8'd3;  k[2] = 8'd1;  k[3] = 8'd1; end
    for (int r = 0; r < 4; r++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gmul(a[(r+j)%4], k[j]);
      res[31-8*r -: 8] = b;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] mblock(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] res = '0;
    for (int c = 0; c < N; c++) res[W-1-32*c -: 32] = mcol(d[W-1-32*c -: 32], inv);
    return res;
  endfunction

  int           m_run = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] q_exp[$];
  int           q_acc[$];
  bit           prev_ov = 1'b0;
  logic [W-1:0] held = '0;

  // One clock cycle: drive at the falling edge, check 1 ns later, advance the cycle model.
  task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit inv,
                      input bit o, input logic [W-1:0] exp);
    @(negedge clk);
    rst = r; iv = v; idat = d; ii = inv; ordy = o;
    #1;
    chk("busy", busy, (m_run > 0));
    chk("out_valid", ovld, m_done);
    chk("in_ready", irdy, (m_run == 0) && (!m_done || o));
    if (ovld && prev_ov) chk("hold_data", odat, held);
    if (ovld && !prev_ov) begin
      chk("ov_pending", (q_acc.size() > 0), 1'b1);
      if (q_acc.size() > 0) chk("latency", cyc - q_acc[0], LAT);
    end
    if (!r) begin
      if (ovld && o && q_exp.size() > 0) begin
        chk("out_data", odat, q_exp.pop_front());
        void'(q_acc.pop_front());
      end
      if (v && irdy) begin
        q_exp.push_back(exp);
        q_acc.push_back(cyc);
      end
    end
    prev_ov = ovld;
    held    = odat;
    if (r) begin
      m_run = 0; m_done = 1'b0;
      q_exp.delete(); q_acc.delete();
    end else if (m_run > 0) begin
      m_run--;
      if (m_run == 0) m_done = 1'b1;
    end else if (m_done) begin
      if (o) begin
        m_done = 1'b0;
        if (v) m_run = N;
      end
    end else if (v) begin
      m_run = N;
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [W-1:0] blk_d[8];
  bit           blk_i[8];
  logic [W-1:0] blk_e[8];

  // Offers blk_* in order; non-accepting cycles carry junk data/mode to show it is ignored.
  task automatic feed(input int nblk, input int pct);
    int sent = 0;
    int lim = 0;
    bit o, acc_now;
    while ((sent < nblk || q_exp.size() > 0 || m_run > 0 || m_done) && lim < 400) begin
      o = ($urandom_range(99) < pct);
      acc_now = (m_run == 0) && (!m_done || o);
      if (acc_now && sent < nblk) begin
        step(1'b0, 1'b1, blk_d[sent], blk_i[sent], o, blk_e[sent]);
        sent++;
      end else begin
        step(1'b0, acc_now ? 1'b0 : 1'($urandom_range(1)), rnd(), 1'($urandom_range(1)), o, '0);
      end
      lim++;
    end
    chk("feed_drained", (lim < 400), 1'b1);
  endtask

  task automatic small_builds();
    int lat1 = -1;
    int lat8 = -1;
    @(negedge clk);
    v1 = 1'b1; d1 = 32'hdb135345;
    v8 = 1'b1; d8 = {8{32'hdb135345}};
    #1;
    chk("n1_in_ready", rdy1, 1'b1);
    chk("n8_in_ready", rdy8, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      v1 = 1'b0; v8 = 1'b0;
      #1;
      if (ov1 && lat1 < 0) begin lat1 = k; chk("n1_data", o1, 32'h8e4da1bc); end
      if (ov8 && lat8 < 0) begin lat8 = k; chk("n8_data", o8, {8{32'h8e4da1bc}}); end
    end
    chk("n1_latency", lat1, 2);
    chk("n8_latency", lat8, 9);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x0, x1;
    @(posedge clk);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, rnd(), 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("reset_out_data", odat, '0);

    blk_d[0] = V_F_IN; blk_i[0] = 1'b0; blk_e[0] = V_F_OUT;
    feed(1, 100);
    blk_d[0] = V_I_IN; blk_i[0] = 1'b1; blk_e[0] = V_I_OUT;
    feed(1, 100);

    x0 = rnd(); x1 = rnd();
    blk_d[0] = x0;              blk_i[0] = 1'b0; blk_e[0] = mblock(x0, 1'b0);
    blk_d[1] = mblock(x0, 1'b0); blk_i[1] = 1'b1; blk_e[1] = x0;
    blk_d[2] = x1;              blk_i[2] = 1'b0; blk_e[2] = mblock(x1, 1'b0);
    blk_d[3] = mblock(x1, 1'b0); blk_i[3] = 1'b1; blk_e[3] = x1;
    blk_d[4] = V_F_IN;          blk_i[4] = 1'b0; blk_e[4] = V_F_OUT;
    feed(5, 100);

    step(1'b0, 1'b1, V_I_IN, 1'b1, 1'b0, V_I_OUT);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, rnd(), 1'($urandom_range(1)), 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rnd(), 1'($urandom_range(1)), 1'b0, '0);
    step(1'b0, 1'b0, rnd(), 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, rnd(), 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, rnd(), 1'b0, 1'b1, '0);

    step(1'b0, 1'b1, V_F_IN, 1'b0, 1'b1, V_F_OUT);
    step(1'b0, 1'b0, rnd(), 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, rnd(), 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, rnd(), 1'b0, 1'b1, '0);
    chk("midrun_reset_data", odat, '0);
    for (int i = 0; i < 2 * N; i++) step(1'b0, 1'b0, rnd(), 1'b0, 1'b1, '0);
    blk_d[0] = V_F_IN; blk_i[0] = 1'b0; blk_e[0] = V_F_OUT;
    feed(1, 100);

    for (int i = 0; i < 6; i++) begin
      blk_d[i] = rnd(); blk_i[i] = 1'($urandom_range(1));
      blk_e[i] = mblock(blk_d[i], blk_i[i]);
    end
    feed(6, 60);

    small_builds();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
